// File: rtl/rbm_gibbs_sequencer.sv
// Runs K Gibbs steps over a hidden (V->H) and visible (H->V) RBM layer pair.
// Start is accepted only in IDLE. A watchdog ends the chain early if a layer hangs.
module rbm_gibbs_sequencer #(
  parameter int VIS_DIM = 15,
  parameter int HID_DIM = 5,
  parameter int GIBBS_K = 1,
  parameter int STEP_W  = 8,
  parameter int TMO_CYC = 1023
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VIS_DIM-1:0] v_in,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [VIS_DIM-1:0] v_out,
  output logic [HID_DIM-1:0] h_out,
  output logic [STEP_W-1:0]  step_cnt,
  output logic               h_rst,
  output logic               h_valid,
  output logic [VIS_DIM-1:0] h_layer_in,
  input  logic [HID_DIM-1:0] h_sample,
  input  logic               h_finish,
  output logic               v_rst,
  output logic               v_valid,
  output logic [HID_DIM-1:0] v_layer_in,
  input  logic [VIS_DIM-1:0] v_sample,
  input  logic               v_finish
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR_H = 3'd1,
    RUN_H = 3'd2,
    CLR_V = 3'd3,
    RUN_V = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0]       TMO_LIM   = 16'(TMO_CYC);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(GIBBS_K - 1);

  state_t             state;
  logic [VIS_DIM-1:0] v_reg;
  logic [HID_DIM-1:0] h_reg;
  logic [15:0]        watchdog;

  // The V and H registers double as the sample outputs and the feed into the opposite layer.
  assign v_out      = v_reg;
  assign h_out      = h_reg;
  assign h_layer_in = v_reg;
  assign v_layer_in = h_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      h_rst    <= 1'b1;
      v_rst    <= 1'b1;
      h_valid  <= 1'b0;
      v_valid  <= 1'b0;
      v_reg    <= '0;
      h_reg    <= '0;
      step_cnt <= '0;
      watchdog <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          h_rst <= 1'b1;
          v_rst <= 1'b1;
          if (start) begin
            v_reg    <= v_in;
            step_cnt <= '0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
            state    <= CLR_H;
          end
        end
        CLR_H: begin
          watchdog <= '0;
          h_rst    <= 1'b0;
          h_valid  <= 1'b1;
          state    <= RUN_H;
        end
        RUN_H: begin
          // A finish arriving on the watchdog limit cycle still counts as a capture.
          if (h_finish) begin
            h_reg   <= h_sample;
            h_valid <= 1'b0;
            h_rst   <= 1'b1;
            state   <= CLR_V;
          end else if (watchdog == TMO_LIM) begin
            timeout <= 1'b1;
            h_valid <= 1'b0;
            h_rst   <= 1'b1;
            state   <= DONE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        CLR_V: begin
          watchdog <= '0;
          v_rst    <= 1'b0;
          v_valid  <= 1'b1;
          state    <= RUN_V;
        end
        RUN_V: begin
          if (v_finish) begin
            v_reg    <= v_sample;
            step_cnt <= step_cnt + 1'b1;
            v_valid  <= 1'b0;
            v_rst    <= 1'b1;
            state    <= (step_cnt == LAST_STEP) ? DONE : CLR_H;
          end else if (watchdog == TMO_LIM) begin
            timeout <= 1'b1;
            v_valid <= 1'b0;
            v_rst   <= 1'b1;
            state   <= DONE;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          h_rst <= 1'b1;
          v_rst <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbm_gibbs_sequencer.sv
// Directed bench: a K=1 and a K=3 sequencer (both TMO_CYC=20) driving behavioural layer stubs.
module tb_rbm_gibbs_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- K=1 DUT with fixed-response stubs ----------------
  logic        start1 = 1'b0;
  logic [14:0] v_in1 = '0;
  logic        busy1, done1, timeout1, h_rst1, h_valid1, v_rst1, v_valid1;
  logic [14:0] v_out1, h_layer_in1, v_sample1;
  logic [4:0]  h_out1, v_layer_in1, h_sample1;
  logic [7:0]  step_cnt1;
  logic        h_finish1, v_finish1;
  int          hl1 = 4, vl1 = 4, hc1 = 0, vc1 = 0;
  logic [4:0]  fh1 = 5'h13;
  logic [14:0] fv1 = 15'h7F00;

  rbm_gibbs_sequencer #(.GIBBS_K(1), .TMO_CYC(20)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .v_in(v_in1),
    .busy(busy1), .done(done1), .timeout(timeout1),
    .v_out(v_out1), .h_out(h_out1), .step_cnt(step_cnt1),
    .h_rst(h_rst1), .h_valid(h_valid1), .h_layer_in(h_layer_in1),
    .h_sample(h_sample1), .h_finish(h_finish1),
    .v_rst(v_rst1), .v_valid(v_valid1), .v_layer_in(v_layer_in1),
    .v_sample(v_sample1), .v_finish(v_finish1));

  // Stub finishes in its Nth cycle out of reset (N = 0 means never).
  always @(posedge clock) begin
    hc1 <= h_rst1 ? 0 : hc1 + 1;
    vc1 <= v_rst1 ? 0 : vc1 + 1;
  end
  assign h_finish1 = h_valid1 && !h_rst1 && (hl1 != 0) && (hc1 == hl1 - 1);
  assign v_finish1 = v_valid1 && !v_rst1 && (vl1 != 0) && (vc1 == vl1 - 1);
  assign h_sample1 = fh1;
  assign v_sample1 = fv1;

  // ---------------- K=3 DUT with echo stubs ----------------
  logic        start3 = 1'b0;
  logic [14:0] v_in3 = '0;
  logic        busy3, done3, timeout3, h_rst3, h_valid3, v_rst3, v_valid3;
  logic [14:0] v_out3, h_layer_in3, v_sample3;
  logic [4:0]  h_out3, v_layer_in3, h_sample3;
  logic [7:0]  step_cnt3;
  logic        h_finish3, v_finish3;
  int          hc3 = 0, vc3 = 0;

  rbm_gibbs_sequencer #(.GIBBS_K(3), .TMO_CYC(20)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .v_in(v_in3),
    .busy(busy3), .done(done3), .timeout(timeout3),
    .v_out(v_out3), .h_out(h_out3), .step_cnt(step_cnt3),
    .h_rst(h_rst3), .h_valid(h_valid3), .h_layer_in(h_layer_in3),
    .h_sample(h_sample3), .h_finish(h_finish3),
    .v_rst(v_rst3), .v_valid(v_valid3), .v_layer_in(v_layer_in3),
    .v_sample(v_sample3), .v_finish(v_finish3));

  always @(posedge clock) begin
    hc3 <= h_rst3 ? 0 : hc3 + 1;
    vc3 <= v_rst3 ? 0 : vc3 + 1;
  end
  assign h_finish3 = h_valid3 && !h_rst3 && (hc3 == 3);
  assign v_finish3 = v_valid3 && !v_rst3 && (vc3 == 3);
  assign h_sample3 = h_layer_in3[4:0] + 5'd1;
  assign v_sample3 = {3{v_layer_in3}};

  // Monitors: done pulses, layer releases (h_rst/v_rst 1->0) and the hidden input at each release.
  int          dcnt1 = 0, dcnt3 = 0, hrel3 = 0, vrel3 = 0;
  logic        hr3_prev = 1'b1, vr3_prev = 1'b1;
  logic [14:0] hlog [8];
  always @(posedge clock) begin
    if (done1) dcnt1 <= dcnt1 + 1;
    if (done3) dcnt3 <= dcnt3 + 1;
    if (hr3_prev && !h_rst3) begin
      hlog[hrel3 % 8] <= h_layer_in3;
      hrel3 <= hrel3 + 1;
    end
    if (vr3_prev && !v_rst3) vrel3 <= vrel3 + 1;
    hr3_prev <= h_rst3;
    vr3_prev <= v_rst3;
  end

  // n counts sampled cycles with the cycle start is raised counted as 1.
  task automatic run1(input logic [14:0] vin, output int n);
    logic got;
    got = 1'b0;
    v_in1 = vin;
    start1 = 1'b1;
    n = 1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      start1 = 1'b0;
      n++;
      got = done1;
    end
    check("done1_arrives", 32'(got), 32'd1);
  endtask

  task automatic run3(input logic [14:0] vin, output int n);
    logic got;
    got = 1'b0;
    v_in3 = vin;
    start3 = 1'b1;
    n = 1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clock);
      start3 = 1'b0;
      n++;
      got = done3;
    end
    check("done3_arrives", 32'(got), 32'd1);
  endtask

  initial begin
    int n, d0, hb, vb;
    logic got;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_tmo", 32'(timeout1), 0);
    check("rst_hrst", 32'(h_rst1), 1);
    check("rst_vrst", 32'(v_rst1), 1);
    check("rst_valids", {h_valid1, v_valid1}, 0);
    check("rst_outs", {v_out1, h_out1, step_cnt1}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: single step, fixed stub responses
    run1(15'h02A5, n);
    check("t1_latency", n, 13);
    check("t1_h_out", h_out1, 5'h13);
    check("t1_v_out", v_out1, 15'h7F00);
    check("t1_step", step_cnt1, 1);
    check("t1_tmo", timeout1, 0);
    @(negedge clock);
    check("t1_busy_low", busy1, 0);
    check("t1_done_pulse", done1, 0);

    // 3: hidden layer hangs, watchdog ends the chain
    hl1 = 0;
    fh1 = 5'h1F;
    run1(15'h0011, n);
    check("t3_latency", n, 25);
    check("t3_tmo", timeout1, 1);
    check("t3_h_out", h_out1, 5'h13);
    check("t3_v_out", v_out1, 15'h0011);
    check("t3_step", step_cnt1, 0);
    repeat (3) @(negedge clock);
    check("t3_tmo_sticky", timeout1, 1);
    hl1 = 4;
    fh1 = 5'h13;
    v_in1 = 15'h02A5;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    check("t3_tmo_cleared", timeout1, 0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = done1;
    end
    check("t3_rerun_done", 32'(got), 1);
    check("t3_rerun_tmo", timeout1, 0);

    // 4: start in RUN_H and in DONE is ignored; held start in IDLE launches
    repeat (2) @(negedge clock);
    d0 = dcnt1;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = !h_rst1;
    end
    check("t4_in_run_h", 32'(got), 1);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = v_finish1;
    end
    check("t4_v_finish", 32'(got), 1);
    @(negedge clock);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    check("t4_done_after_done_state", done1, 1);
    repeat (10) @(negedge clock);
    check("t4_one_done", dcnt1 - d0, 1);
    check("t4_idle", busy1, 0);
    start1 = 1'b1;
    @(negedge clock);
    check("t4_held_launch", busy1, 1);
    repeat (2) @(negedge clock);
    start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = done1;
    end
    check("t4_second_done", 32'(got), 1);
    @(negedge clock);
    check("t4_two_dones", dcnt1 - d0, 2);

    // 6: v_finish on the watchdog limit cycle still captures
    repeat (2) @(negedge clock);
    fh1 = 5'h0A;
    fv1 = 15'h1234;
    vl1 = 21;
    run1(15'h0001, n);
    check("t6_latency", n, 30);
    check("t6_tmo", timeout1, 0);
    check("t6_v_out", v_out1, 15'h1234);
    check("t6_h_out", h_out1, 5'h0A);
    check("t6_step", step_cnt1, 1);

    // 2: K=3 chain with echo stubs (h = v[4:0]+1, v = {h,h,h})
    hb = hrel3;
    vb = vrel3;
    d0 = dcnt3;
    run3(15'h0003, n);
    @(negedge clock);
    check("t2_h_runs", hrel3 - hb, 3);
    check("t2_v_runs", vrel3 - vb, 3);
    check("t2_hin_step1", hlog[hb % 8], 15'h0003);
    check("t2_hin_step2", hlog[(hb + 1) % 8], 15'h1084);
    check("t2_hin_step3", hlog[(hb + 2) % 8], 15'h14A5);
    check("t2_step", step_cnt3, 3);
    check("t2_h_out", h_out3, 5'h06);
    check("t2_v_out", v_out3, 15'h18C6);
    check("t2_one_done", dcnt3 - d0, 1);

    // 5: reset during RUN_V of step 2
    repeat (2) @(negedge clock);
    vb = vrel3;
    d0 = dcnt3;
    v_in3 = 15'h0003;
    start3 = 1'b1;
    @(negedge clock);
    start3 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      got = (vrel3 - vb == 2);
    end
    check("t5_reach_run_v2", 32'(got), 1);
    check("t5_step_before", step_cnt3, 1);
    reset = 1'b1;
    #1;
    check("t5_busy", busy3, 0);
    check("t5_rsts", {h_rst3, v_rst3}, 2'b11);
    check("t5_valids", {h_valid3, v_valid3}, 0);
    check("t5_outs", {v_out3, h_out3, step_cnt3}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("t5_no_done", dcnt3 - d0, 0);
    run3(15'h0003, n);
    check("t5_rerun_step", step_cnt3, 3);
    check("t5_rerun_v_out", v_out3, 15'h18C6);
    check("t5_rerun_tmo", timeout3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
